// File: rtl/eth_pkg.sv
// Shared definitions for the two-port Ethernet egress arbiter:
// word layout, bit positions and the arbiter state type.
package eth_pkg;

  localparam int WORD_W  = 34;
  localparam int EOP_BIT = 33;
  localparam int SOP_BIT = 32;

  // Arbiter states; encoding kept explicit so it is stable across tools.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XFER_A = 2'd1,
    ST_XFER_B = 2'd2
  } arb_state_e;

  // Start-of-packet marker of a FIFO word.
  function automatic logic is_sop(input logic [WORD_W-1:0] word);
    return word[SOP_BIT];
  endfunction

  // End-of-packet marker of a FIFO word.
  function automatic logic is_eop(input logic [WORD_W-1:0] word);
    return word[EOP_BIT];
  endfunction

endpackage

// File: rtl/eth_rr_arb2.sv
// Two-way round-robin picker. elig_i[0] is port A, elig_i[1] is port B.
// last_b_i=1 means B was granted most recently, so A wins a tie.
module eth_rr_arb2 (
  input  logic [1:0] elig_i,
  input  logic       last_b_i,
  output logic       gnt_valid_o,
  output logic       gnt_b_o
);

  // Pick a winner from the eligible set, alternating on ties.
  always_comb begin
    gnt_valid_o = |elig_i;
    gnt_b_o     = 1'b0;
    case (elig_i)
      2'b01:   gnt_b_o = 1'b0;
      2'b10:   gnt_b_o = 1'b1;
      2'b11:   gnt_b_o = ~last_b_i;
      default: gnt_b_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/eth_port_arb.sv
// Packet-atomic two-port arbiter merging ingress FIFOs A and B onto one
// egress stream. Words of one packet are never interleaved with the other
// port; stray non-sop words seen while idle are discarded and counted.
module eth_port_arb
  import eth_pkg::*;
#(
  parameter int PKT_CNT_W  = 16,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inEmptyA,
  input  logic                  inEmptyB,
  input  logic [WORD_W-1:0]     inDataA,
  input  logic [WORD_W-1:0]     inDataB,
  output logic                  outRdEnA,
  output logic                  outRdEnB,
  input  logic                  outFull,
  output logic                  outWrEn,
  output logic [WORD_W-1:0]     outData,
  output logic [PKT_CNT_W-1:0]  pktCntA,
  output logic [PKT_CNT_W-1:0]  pktCntB,
  output logic [DROP_CNT_W-1:0] dropCnt,
  output logic                  errSop
);

  arb_state_e            state_q, state_d;
  logic                  last_b_q, last_b_d;
  logic                  first_q, first_d;
  logic                  wr_en_q, wr_en_d;
  logic [WORD_W-1:0]     data_q, data_d;
  logic                  err_q, err_d;
  logic [PKT_CNT_W-1:0]  pkt_a_q, pkt_a_d;
  logic [PKT_CNT_W-1:0]  pkt_b_q, pkt_b_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic                  rd_a, rd_b;
  logic [1:0]            elig;
  logic                  gnt_valid, gnt_b;
  logic                  sel_b;
  logic                  head_empty;
  logic [WORD_W-1:0]     head_word;
  logic [1:0]            drop_inc;
  logic [DROP_CNT_W:0]   drop_sum;

  assign elig[0] = !inEmptyA && is_sop(inDataA);
  assign elig[1] = !inEmptyB && is_sop(inDataB);

  eth_rr_arb2 u_rr (
    .elig_i      (elig),
    .last_b_i    (last_b_q),
    .gnt_valid_o (gnt_valid),
    .gnt_b_o     (gnt_b)
  );

  // Head of the FIFO currently owning the grant.
  assign sel_b      = (state_q == ST_XFER_B);
  assign head_word  = sel_b ? inDataB : inDataA;
  assign head_empty = sel_b ? inEmptyB : inEmptyA;

  // Saturating drop counter sum; both ports may discard in the same cycle.
  assign drop_inc = {1'b0, rd_a} + {1'b0, rd_b};
  assign drop_sum = {1'b0, drop_q} + {{(DROP_CNT_W-1){1'b0}}, drop_inc};

  // Next-state, pop strobes and egress word selection.
  always_comb begin
    state_d = state_q;
    last_b_d = last_b_q;
    first_d  = first_q;
    wr_en_d  = 1'b0;
    data_d   = data_q;
    err_d    = 1'b0;
    pkt_a_d  = pkt_a_q;
    pkt_b_d  = pkt_b_q;
    drop_d   = drop_q;
    rd_a     = 1'b0;
    rd_b     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A granted head carries sop, so it is never caught by the discard.
        rd_a = !inEmptyA && !is_sop(inDataA);
        rd_b = !inEmptyB && !is_sop(inDataB);
        if (drop_sum[DROP_CNT_W]) begin
          drop_d = {DROP_CNT_W{1'b1}};
        end else begin
          drop_d = drop_sum[DROP_CNT_W-1:0];
        end
        if (gnt_valid) begin
          state_d = gnt_b ? ST_XFER_B : ST_XFER_A;
          first_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER_A, ST_XFER_B: begin
        if (!head_empty && !outFull) begin
          rd_a    = !sel_b;
          rd_b    = sel_b;
          wr_en_d = 1'b1;
          data_d  = head_word;
          first_d = 1'b0;
          // A second sop inside a grant is forwarded but flagged.
          if (is_sop(head_word) && !first_q) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
          end
          if (is_eop(head_word)) begin
            state_d  = ST_IDLE;
            last_b_d = sel_b;
            if (sel_b) begin
              pkt_b_d = pkt_b_q + {{(PKT_CNT_W-1){1'b0}}, 1'b1};
            end else begin
              pkt_a_d = pkt_a_q + {{(PKT_CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_d = state_q;
          end
        end else begin
          // Empty FIFO or egress backpressure: hold the grant, no timeout.
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // No pops may reach the FIFOs while reset is held.
  assign outRdEnA = rd_a && !reset;
  assign outRdEnB = rd_b && !reset;

  // Arbiter state and registered egress/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      last_b_q <= 1'b1;
      first_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      data_q   <= {WORD_W{1'b0}};
      err_q    <= 1'b0;
      pkt_a_q  <= {PKT_CNT_W{1'b0}};
      pkt_b_q  <= {PKT_CNT_W{1'b0}};
      drop_q   <= {DROP_CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      first_q  <= first_d;
      wr_en_q  <= wr_en_d;
      data_q   <= data_d;
      err_q    <= err_d;
      pkt_a_q  <= pkt_a_d;
      pkt_b_q  <= pkt_b_d;
      drop_q   <= drop_d;
    end
  end

  assign outWrEn = wr_en_q;
  assign outData = data_q;
  assign pktCntA = pkt_a_q;
  assign pktCntB = pkt_b_q;
  assign dropCnt = drop_q;
  assign errSop  = err_q;

endmodule

// File: tb/tb_eth_port_arb.sv
// Directed self-checking bench for eth_port_arb with behavioural FWFT
// ingress FIFOs and an egress capture monitor.
module tb_eth_port_arb;

  localparam int PW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          inEmptyA, inEmptyB;
  logic [33:0]   inDataA, inDataB;
  logic          outRdEnA, outRdEnB;
  logic          outFull = 1'b0;
  logic          outWrEn;
  logic [33:0]   outData;
  logic [PW-1:0] pktCntA, pktCntB;
  logic [DW-1:0] dropCnt;
  logic          errSop;

  int total = 0;
  int passed = 0;

  eth_port_arb #(.PKT_CNT_W(PW), .DROP_CNT_W(DW)) dut (
    .clk(clk), .reset(reset),
    .inEmptyA(inEmptyA), .inEmptyB(inEmptyB),
    .inDataA(inDataA), .inDataB(inDataB),
    .outRdEnA(outRdEnA), .outRdEnB(outRdEnB),
    .outFull(outFull), .outWrEn(outWrEn), .outData(outData),
    .pktCntA(pktCntA), .pktCntB(pktCntB),
    .dropCnt(dropCnt), .errSop(errSop)
  );

  always #5 clk = ~clk;

  // Ingress FIFO models: bench writes, DUT pops via outRdEn.
  logic [33:0] mem_a [0:4095];
  logic [33:0] mem_b [0:4095];
  logic [11:0] wp_a = 12'd0, wp_b = 12'd0;
  logic [11:0] rp_a = 12'd0, rp_b = 12'd0;
  assign inEmptyA = (rp_a == wp_a);
  assign inEmptyB = (rp_b == wp_b);
  assign inDataA  = mem_a[rp_a];
  assign inDataB  = mem_b[rp_b];

  always @(posedge clk) begin
    if (outRdEnA) rp_a <= rp_a + 12'd1;
    if (outRdEnB) rp_b <= rp_b + 12'd1;
  end

  // Egress monitor.
  logic [33:0] cap [$];
  int err_cnt = 0;
  always @(negedge clk) begin
    if (outWrEn) cap.push_back(outData);
    if (errSop) err_cnt++;
  end

  function automatic logic [33:0] mk(input logic sop, input logic eop, input logic [31:0] pl);
    return {eop, sop, pl};
  endfunction

  task automatic push_a(input logic [33:0] w);
    mem_a[wp_a] = w;
    wp_a = wp_a + 12'd1;
  endtask

  task automatic push_b(input logic [33:0] w);
    mem_b[wp_b] = w;
    wp_b = wp_b + 12'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    push_a(mk(1'b0, 1'b0, 32'h0000_DEAD));
    #1;
    total++; if (outWrEn !== 1'b0) $display("FAIL rst_wr got %b want 0", outWrEn); else passed++;
    total++; if (outData !== 34'd0) $display("FAIL rst_data got %h want 0", outData); else passed++;
    total++; if (pktCntA !== 16'd0 || pktCntB !== 16'd0) $display("FAIL rst_pkt got %0d/%0d want 0/0", pktCntA, pktCntB); else passed++;
    total++; if (dropCnt !== 8'd0) $display("FAIL rst_drop got %0d want 0", dropCnt); else passed++;
    total++; if (errSop !== 1'b0) $display("FAIL rst_err got %b want 0", errSop); else passed++;
    total++; if (outRdEnA !== 1'b0 || outRdEnB !== 1'b0) $display("FAIL rst_rden got %b%b want 00", outRdEnA, outRdEnB); else passed++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (dropCnt !== 8'd1) $display("FAIL rst_stray_drop got %0d want 1", dropCnt); else passed++;
  endtask

  task automatic test_single_a();
    logic [33:0] w [3];
    logic ew [6];
    w[0] = mk(1'b1, 1'b0, 32'hA000_0001);
    w[1] = mk(1'b0, 1'b0, 32'hA000_0002);
    w[2] = mk(1'b0, 1'b1, 32'hA000_0003);
    ew = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push_a(w[i]);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (outWrEn !== ew[c]) $display("FAIL single_wr c%0d got %b want %b", c, outWrEn, ew[c]);
      else passed++;
      if (c >= 2 && c <= 4) begin
        total++;
        if (outData !== w[c-2]) $display("FAIL single_data c%0d got %h want %h", c, outData, w[c-2]);
        else passed++;
      end
      if (c == 0) begin
        total++; if (outRdEnA !== 1'b0) $display("FAIL single_rden_T got %b want 0", outRdEnA); else passed++;
      end
      if (c == 1) begin
        total++; if (outRdEnA !== 1'b1) $display("FAIL single_rden_T1 got %b want 1", outRdEnA); else passed++;
      end
    end
    total++; if (pktCntA !== 16'd1 || pktCntB !== 16'd0) $display("FAIL single_pkt got %0d/%0d want 1/0", pktCntA, pktCntB); else passed++;
  endtask

  task automatic test_tie();
    logic [33:0] wa [2];
    logic [33:0] wb [2];
    logic ew [8];
    wa[0] = mk(1'b1, 1'b0, 32'hAA00_0001); wa[1] = mk(1'b0, 1'b1, 32'hAA00_0002);
    wb[0] = mk(1'b1, 1'b0, 32'hBB00_0001); wb[1] = mk(1'b0, 1'b1, 32'hBB00_0002);
    ew = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    @(posedge clk); #1;
    push_a(wa[0]); push_a(wa[1]); push_b(wb[0]); push_b(wb[1]);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (outWrEn !== ew[c]) $display("FAIL tie_wr c%0d got %b want %b", c, outWrEn, ew[c]);
      else passed++;
      if (c == 2 || c == 3) begin
        total++;
        if (outData !== wa[c-2]) $display("FAIL tie_data_a c%0d got %h want %h", c, outData, wa[c-2]); else passed++;
      end
      if (c == 5 || c == 6) begin
        total++;
        if (outData !== wb[c-5]) $display("FAIL tie_data_b c%0d got %h want %h", c, outData, wb[c-5]); else passed++;
      end
    end
    total++; if (pktCntA !== 16'd1 || pktCntB !== 16'd1) $display("FAIL tie_pkt got %0d/%0d want 1/1", pktCntA, pktCntB); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [33:0] p0, p1;
    logic ew [6];
    p0 = mk(1'b1, 1'b1, 32'hC000_0000);
    p1 = mk(1'b1, 1'b1, 32'hC000_0001);
    ew = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    @(posedge clk); #1;
    push_a(p0); push_a(p1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (outWrEn !== ew[c]) $display("FAIL b2b_wr c%0d got %b want %b", c, outWrEn, ew[c]); else passed++;
      if (c == 2) begin
        total++; if (outData !== p0) $display("FAIL b2b_p0 got %h want %h", outData, p0); else passed++;
      end
      if (c == 4) begin
        total++; if (outData !== p1) $display("FAIL b2b_p1 got %h want %h", outData, p1); else passed++;
      end
    end
    total++; if (pktCntA !== 16'd3) $display("FAIL b2b_pkt got %0d want 3", pktCntA); else passed++;
  endtask

  task automatic test_drop();
    bit saw_wr;
    bit drained;
    saw_wr = 1'b0;
    drained = 1'b0;
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) push_a(mk(1'b0, 1'b0, i));
    @(negedge clk);
    total++; if (outRdEnA !== 1'b1) $display("FAIL drop_rden got %b want 1", outRdEnA); else passed++;
    total++; if (dropCnt !== 8'd0) $display("FAIL drop_cnt0 got %0d want 0", dropCnt); else passed++;
    @(negedge clk);
    total++; if (dropCnt !== 8'd1) $display("FAIL drop_cnt1 got %0d want 1", dropCnt); else passed++;
    for (int c = 0; c < 400 && !drained; c++) begin
      @(negedge clk);
      if (outWrEn) saw_wr = 1'b1;
      if (inEmptyA) drained = 1'b1;
    end
    @(negedge clk);
    total++; if (!drained) $display("FAIL drop_drain got busy want empty"); else passed++;
    total++; if (saw_wr) $display("FAIL drop_nowr got write want none"); else passed++;
    total++; if (dropCnt !== 8'd255) $display("FAIL drop_sat got %0d want 255", dropCnt); else passed++;
  endtask

  task automatic test_stall();
    logic [33:0] w [5];
    int base;
    logic [PW-1:0] pkt0;
    base = cap.size();
    pkt0 = pktCntA;
    for (int i = 0; i < 5; i++) w[i] = mk(i == 0, i == 4, 32'hD000_0000 + i);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) push_a(w[i]);
    for (int c = 0; c < 13; c++) begin
      outFull = (c >= 3 && c <= 6);
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        total++; if (outRdEnA !== 1'b0) $display("FAIL stall_rden c%0d got %b want 0", c, outRdEnA); else passed++;
      end
      if (c == 7) begin
        total++; if (outRdEnA !== 1'b1) $display("FAIL stall_resume got %b want 1", outRdEnA); else passed++;
      end
      @(posedge clk); #1;
    end
    outFull = 1'b0;
    total++;
    if (cap.size() - base !== 5) $display("FAIL stall_count got %0d want 5", cap.size() - base);
    else begin
      passed++;
      for (int i = 0; i < 5; i++) begin
        total++;
        if (cap[base+i] !== w[i]) $display("FAIL stall_word%0d got %h want %h", i, cap[base+i], w[i]); else passed++;
      end
    end
    total++; if (pktCntA !== pkt0 + 16'd1) $display("FAIL stall_pkt got %0d want %0d", pktCntA, pkt0 + 16'd1); else passed++;
  endtask

  task automatic test_err_sop();
    logic [33:0] w [4];
    int base, ebase;
    base = cap.size();
    do_reset();
    ebase = err_cnt;
    w[0] = mk(1'b1, 1'b0, 32'hE000_0000);
    w[1] = mk(1'b0, 1'b0, 32'hE000_0001);
    w[2] = mk(1'b1, 1'b0, 32'hE000_0002);
    w[3] = mk(1'b0, 1'b1, 32'hE000_0003);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push_a(w[i]);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (errSop !== (c == 4)) $display("FAIL errsop_c%0d got %b want %b", c, errSop, (c == 4)); else passed++;
    end
    total++; if (err_cnt - ebase !== 1) $display("FAIL errsop_pulses got %0d want 1", err_cnt - ebase); else passed++;
    total++;
    if (cap.size() - base !== 4) $display("FAIL errsop_count got %0d want 4", cap.size() - base);
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (cap[base+i] !== w[i]) $display("FAIL errsop_word%0d got %h want %h", i, cap[base+i], w[i]); else passed++;
      end
    end
    total++; if (pktCntA !== 16'd1) $display("FAIL errsop_pkt got %0d want 1", pktCntA); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [33:0] pa, pb;
    int base;
    @(posedge clk); #1;
    push_a(mk(1'b1, 1'b0, 32'hF000_0000));
    push_a(mk(1'b0, 1'b0, 32'hF000_0001));
    push_a(mk(1'b0, 1'b0, 32'hF000_0002));
    push_a(mk(1'b0, 1'b1, 32'hF000_0003));
    repeat (4) @(negedge clk);
    total++; if (outWrEn !== 1'b1) $display("FAIL rmid_pre_wr got %b want 1", outWrEn); else passed++;
    #1 reset = 1'b1;
    #1;
    total++; if (outWrEn !== 1'b0) $display("FAIL rmid_wr got %b want 0", outWrEn); else passed++;
    total++; if (outData !== 34'd0) $display("FAIL rmid_data got %h want 0", outData); else passed++;
    total++; if (pktCntA !== 16'd0 || pktCntB !== 16'd0) $display("FAIL rmid_pkt got %0d/%0d want 0/0", pktCntA, pktCntB); else passed++;
    total++; if (outRdEnA !== 1'b0) $display("FAIL rmid_rden got %b want 0", outRdEnA); else passed++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (dropCnt !== 8'd2) $display("FAIL rmid_drop got %0d want 2", dropCnt); else passed++;
    total++; if (inEmptyA !== 1'b1) $display("FAIL rmid_flush got %b want 1", inEmptyA); else passed++;
    base = cap.size();
    pa = mk(1'b1, 1'b1, 32'h1234_0A0A);
    pb = mk(1'b1, 1'b1, 32'h1234_0B0B);
    push_a(pa); push_b(pb);
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (cap.size() - base !== 2) $display("FAIL rmid_count got %0d want 2", cap.size() - base);
    else begin
      passed++;
      total++; if (cap[base] !== pa) $display("FAIL rmid_first got %h want %h", cap[base], pa); else passed++;
      total++; if (cap[base+1] !== pb) $display("FAIL rmid_second got %h want %h", cap[base+1], pb); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_tie();
    test_back_to_back();
    test_drop();
    test_stall();
    test_err_sop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/eth_port_arb.md
ETH_PORT_ARB -- requirements
Module: eth_port_arb

Interface
REQ-001 Parameter: PKT_CNT_W, 16, width of per-port forwarded-packet counters.
REQ-002 Parameter: DROP_CNT_W, 8, width of saturating drop counter.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 inEmptyA / inEmptyB  in  1  ingress FIFO empty, first-word-fall-through.
REQ-006 inDataA / inDataB  in  34  FIFO head word; bit33 = eop, bit32 = sop, bits31:0 = payload.
REQ-007 outRdEnA / outRdEnB  out  1  combinational pop strobe to the ingress FIFO.
REQ-008 outFull  in  1  egress not able to accept; asserted with at least 1 word of slack.
REQ-009 outWrEn  out  1  registered egress write strobe.
REQ-010 outData  out  34  registered egress word, same format as inData.
REQ-011 pktCntA / pktCntB  out  PKT_CNT_W  packets forwarded per port, wrapping.
REQ-012 dropCnt  out  DROP_CNT_W  words discarded in IDLE, saturating.
REQ-013 errSop  out  1  one-cycle pulse: sop seen mid-packet.

Function
REQ-014 FSM states: IDLE, XFER_A, XFER_B; packet-atomic grant, no interleaving of words from different ports.
REQ-015 IDLE: port x is eligible when !inEmptyx and inDatax[32]=1.
REQ-016 IDLE, one port eligible: next state XFER_x.
REQ-017 IDLE, both eligible: grant to the port not in lastGrant (round-robin); lastGrant resets to B, so A wins the first tie.
REQ-018 IDLE, port x non-empty with head sop=0 and not granted this cycle: pop and discard (outRdEnx=1), dropCnt+1, saturate at all-ones.
REQ-019 XFER_x: outRdEnx = !inEmptyx && !outFull; other port's outRdEn = 0.
REQ-020 Each pop in XFER_x registers inDatax onto outData with outWrEn=1 the next cycle; otherwise outWrEn=0 and outData holds.
REQ-021 Latency: eligible head at cycle T -> XFER at T+1 -> first pop T+1 -> outWrEn at T+2.
REQ-022 Popped word with eop=1 in XFER_x: next state IDLE, lastGrant<=x, pktCntx+1 (wraps).
REQ-023 One mandatory IDLE cycle between consecutive packets.
REQ-024 Single-word packet (sop=1, eop=1) handled per REQ-022: one pop, then IDLE.
REQ-025 Popped word with sop=1 that is not the first word of the grant: forwarded unchanged, errSop pulses the following cycle, grant held until eop.
REQ-026 FIFO empty mid-packet: stall in XFER_x, no outWrEn, no timeout.
REQ-027 outFull mid-packet: no pop, state held; resumes on the first cycle outFull=0.

Reset
REQ-028 reset asserted: state=IDLE, lastGrant=B, outWrEn=0, outData=0, pktCntA=pktCntB=0, dropCnt=0, errSop=0, immediately and asynchronously.
REQ-029 outRdEnA/B = 0 while reset is asserted.
REQ-030 Reset mid-packet: packet abandoned without eop; downstream truncation accepted.

Structure
REQ-031 Shared package eth_pkg: WORD_W=34, EOP_BIT=33, SOP_BIT=32, arbiter state enum type.
REQ-032 One sub-module eth_rr_arb2: 2-way round-robin pick from eligible vector and lastGrant, combinational.

Verification
REQ-033 Scenario: A holds 3-word packet (sop, -, eop), B empty -> outWrEn high 3 consecutive cycles from T+2, pktCntA=1.
REQ-034 Scenario: A and B each present 2-word packet in the same cycle after reset -> A forwarded first, 1 IDLE gap, then B; pktCntA=pktCntB=1.
REQ-035 Scenario: A head word sop=0 in IDLE -> word popped, no outWrEn, dropCnt=1; saturates at 255 after 300 such words.
REQ-036 Scenario: outFull high for 4 cycles mid 5-word packet -> no pops during stall, all 5 words out in order, no duplicates.
REQ-037 Scenario: words sop,-,sop,eop from A -> 4 words forwarded, errSop pulses once, pktCntA=1.
REQ-038 Scenario: reset asserted after 2nd word of 4-word packet -> outWrEn=0 asynchronously, counters 0, next A packet granted first.
